// File: rtl/operand_fetch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | operand_fetch_pkg : widths, x0 constant and operand-resolve helper |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package operand_fetch_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 32;

   localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

   typedef struct packed {
      logic                  wen;
      logic [REG_ADDR_W-1:0] rd;
      logic [DATA_W-1:0]     data;
   } rob_wr_t;

   // Newer write wins: the capture-edge commit is checked after the pending one.
   function automatic logic [DATA_W-1:0] resolve_operand(
      input logic                  flag,
      input logic [REG_ADDR_W-1:0] rs,
      input logic [DATA_W-1:0]     rf_data,
      input rob_wr_t               pend_wr,
      input rob_wr_t               cur_wr
   );
      logic [DATA_W-1:0] val;
      val = '0;
      if (flag) begin
         val = rf_data;
         if (pend_wr.wen && (pend_wr.rd == rs) && (rs != REG_X0)) val = pend_wr.data;
         if (cur_wr.wen && (cur_wr.rd == rs) && (rs != REG_X0))   val = cur_wr.data;
      end
      return val;
   endfunction

endpackage
`default_nettype wire

// File: rtl/operand_fetch_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | operand_fetch_if : dispatch, register-file, commit and result bus  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface operand_fetch_if #(
   parameter int RS_WIDTH = 2
);
   import operand_fetch_pkg::*;

   logic                  req_valid;
   logic                  req_ready;
   logic [RS_WIDTH-1:0]   req_index;
   logic                  req_rs1_flag;
   logic                  req_rs2_flag;
   logic [REG_ADDR_W-1:0] req_rs1;
   logic [REG_ADDR_W-1:0] req_rs2;

   logic                  to_rf_rs1_flag;
   logic                  to_rf_rs2_flag;
   logic [REG_ADDR_W-1:0] to_rf_rs1;
   logic [REG_ADDR_W-1:0] to_rf_rs2;
   logic [RS_WIDTH-1:0]   to_rf_index;

   logic                  from_rf_rs1_flag;
   logic                  from_rf_rs2_flag;
   logic [DATA_W-1:0]     from_rf_rs1;
   logic [DATA_W-1:0]     from_rf_rs2;
   logic [RS_WIDTH-1:0]   from_rf_index;

   logic                  from_rob;
   logic [REG_ADDR_W-1:0] from_rob_rd;
   logic [DATA_W-1:0]     from_rob_wdata;

   logic                  op_valid;
   logic [RS_WIDTH-1:0]   op_index;
   logic [DATA_W-1:0]     op_rs1;
   logic [DATA_W-1:0]     op_rs2;

   modport master (
      output req_valid, req_index, req_rs1_flag, req_rs2_flag, req_rs1, req_rs2,
      input  req_ready,
      input  to_rf_rs1_flag, to_rf_rs2_flag, to_rf_rs1, to_rf_rs2, to_rf_index,
      output from_rf_rs1_flag, from_rf_rs2_flag, from_rf_rs1, from_rf_rs2, from_rf_index,
      output from_rob, from_rob_rd, from_rob_wdata,
      input  op_valid, op_index, op_rs1, op_rs2
   );

   modport slave (
      input  req_valid, req_index, req_rs1_flag, req_rs2_flag, req_rs1, req_rs2,
      output req_ready,
      output to_rf_rs1_flag, to_rf_rs2_flag, to_rf_rs1, to_rf_rs2, to_rf_index,
      input  from_rf_rs1_flag, from_rf_rs2_flag, from_rf_rs1, from_rf_rs2, from_rf_index,
      input  from_rob, from_rob_rd, from_rob_wdata,
      output op_valid, op_index, op_rs1, op_rs2
   );

endinterface
`default_nettype wire

// File: rtl/operand_req_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | operand_req_fifo : power-of-two request queue with stall and clear |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module operand_req_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  wire logic             clk_in,
   input  wire logic             rst_n_in,
   input  wire logic             en,
   input  wire logic             clear,
   input  wire logic             push,
   input  wire logic [WIDTH-1:0] push_data,
   input  wire logic             pop,
   output logic      [WIDTH-1:0] head_data,
   output logic                  empty,
   output logic                  full
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             push_ok;
   logic             pop_ok;

   assign empty     = (count == '0);
   assign full      = (count == (PTR_W+1)'(DEPTH));
   assign push_ok   = push && !full;
   assign pop_ok    = pop && !empty;
   assign head_data = mem[rd_ptr];

   // Depth is a power of two, so pointers wrap by natural overflow.
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (en) begin
         if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_ok);
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_n_in && en && !clear && push_ok) mem[wr_ptr] <= push_data;
   end

endmodule
`default_nettype wire

// File: rtl/operand_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | operand_fetch : queue -> RF issue -> pending -> bypassed capture   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module operand_fetch
   import operand_fetch_pkg::*;
#(
   parameter int RS_WIDTH   = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  wire logic      clk_in,
   input  wire logic      rst_n_in,
   input  wire logic      rdy_in,
   input  wire logic      flush_in,
   operand_fetch_if.slave bus
);
   typedef struct packed {
      logic [RS_WIDTH-1:0]   index;
      logic                  rs1_flag;
      logic                  rs2_flag;
      logic [REG_ADDR_W-1:0] rs1;
      logic [REG_ADDR_W-1:0] rs2;
   } req_t;

   req_t              push_entry;
   req_t              head_entry;
   logic              fifo_empty;
   logic              fifo_full;
   logic              push;
   logic              pop;

   req_t              issue_req;
   logic              issue_valid;
   req_t              pend_req;
   logic              pend_valid;
   rob_wr_t           pend_wr;
   rob_wr_t           cur_wr;

   logic              out_valid;
   logic [RS_WIDTH-1:0] out_index;
   logic [DATA_W-1:0] out_rs1;
   logic [DATA_W-1:0] out_rs2;
   logic [DATA_W-1:0] cap_rs1;
   logic [DATA_W-1:0] cap_rs2;

   // The pending stage is authoritative; RF echo fields are not consulted.
   logic unused_rf_echo;
   assign unused_rf_echo = ^{bus.from_rf_rs1_flag, bus.from_rf_rs2_flag, bus.from_rf_index};

   assign push_entry = '{index: bus.req_index, rs1_flag: bus.req_rs1_flag,
                         rs2_flag: bus.req_rs2_flag, rs1: bus.req_rs1, rs2: bus.req_rs2};
   assign bus.req_ready = rst_n_in && !fifo_full;
   assign push = bus.req_valid && bus.req_ready && !flush_in;
   assign pop  = !fifo_empty && !flush_in;

   operand_req_fifo #(
      .WIDTH ($bits(req_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_in    (clk_in),
      .rst_n_in  (rst_n_in),
      .en        (rdy_in),
      .clear     (flush_in),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .head_data (head_entry),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   assign cur_wr  = '{wen: bus.from_rob, rd: bus.from_rob_rd, data: bus.from_rob_wdata};
   assign cap_rs1 = resolve_operand(pend_req.rs1_flag, pend_req.rs1, bus.from_rf_rs1, pend_wr, cur_wr);
   assign cap_rs2 = resolve_operand(pend_req.rs2_flag, pend_req.rs2, bus.from_rf_rs2, pend_wr, cur_wr);

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         issue_req   <= '0;
         issue_valid <= 1'b0;
         pend_req    <= '0;
         pend_valid  <= 1'b0;
         pend_wr     <= '0;
         out_valid   <= 1'b0;
         out_index   <= '0;
         out_rs1     <= '0;
         out_rs2     <= '0;
      end else if (rdy_in) begin
         if (flush_in) begin
            issue_valid        <= 1'b0;
            issue_req.rs1_flag <= 1'b0;
            issue_req.rs2_flag <= 1'b0;
            pend_valid         <= 1'b0;
            out_valid          <= 1'b0;
         end else begin
            issue_valid <= pop;
            if (pop) begin
               issue_req <= head_entry;
            end else begin
               issue_req.rs1_flag <= 1'b0;
               issue_req.rs2_flag <= 1'b0;
            end
            pend_valid <= issue_valid;
            pend_req   <= issue_req;
            pend_wr    <= cur_wr;
            out_valid  <= pend_valid;
            if (pend_valid) begin
               out_index <= pend_req.index;
               out_rs1   <= cap_rs1;
               out_rs2   <= cap_rs2;
            end
         end
      end
   end

   assign bus.to_rf_rs1_flag = issue_req.rs1_flag;
   assign bus.to_rf_rs2_flag = issue_req.rs2_flag;
   assign bus.to_rf_rs1      = issue_req.rs1;
   assign bus.to_rf_rs2      = issue_req.rs2;
   assign bus.to_rf_index    = issue_req.index;

   assign bus.op_valid = out_valid;
   assign bus.op_index = out_index;
   assign bus.op_rs1   = out_rs1;
   assign bus.op_rs2   = out_rs2;

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_operand_fetch : directed bench with a one-edge register file    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_operand_fetch;
   import operand_fetch_pkg::*;

   localparam int RS_WIDTH   = 2;
   localparam int FIFO_DEPTH = 4;

   localparam logic [1:0]  BB_IDX [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
   localparam logic        BB_F1  [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
   localparam logic        BB_F2  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
   localparam logic [4:0]  BB_RS1 [5] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd8};
   localparam logic [4:0]  BB_RS2 [5] = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd14};
   localparam logic [31:0] BB_E1  [5] = '{32'h1001, 32'h1002, 32'h0, 32'h1004, 32'h0};
   localparam logic [31:0] BB_E2  [5] = '{32'h100A, 32'h0, 32'h100C, 32'h100D, 32'h0};

   logic clk_in = 1'b0;
   logic rst_n_in;
   logic rdy_in;
   logic flush_in;
   int   checks = 0;
   int   errors = 0;
   int   next_k;

   operand_fetch_if #(.RS_WIDTH(RS_WIDTH)) bus ();

   operand_fetch #(
      .RS_WIDTH   (RS_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .rdy_in   (rdy_in),
      .flush_in (flush_in),
      .bus      (bus.slave)
   );

   always #5 clk_in = ~clk_in;

   function automatic logic [31:0] init_val(input int i);
      if (i == 0) return 32'h0;
      if (i == 5) return 32'h11;
      if (i == 6) return 32'h22;
      return 32'h1000 + i;
   endfunction

   // Register file: read-before-write, response one edge after the request.
   logic [31:0] regs [32];
   always @(posedge clk_in) begin
      if (!rst_n_in) begin
         for (int i = 0; i < 32; i++) regs[i] <= init_val(i);
         bus.from_rf_rs1_flag <= 1'b0;
         bus.from_rf_rs2_flag <= 1'b0;
         bus.from_rf_rs1      <= '0;
         bus.from_rf_rs2      <= '0;
         bus.from_rf_index    <= '0;
      end else if (rdy_in) begin
         if (bus.from_rob && bus.from_rob_rd != 5'd0) regs[bus.from_rob_rd] <= bus.from_rob_wdata;
         bus.from_rf_rs1_flag <= bus.to_rf_rs1_flag;
         bus.from_rf_rs2_flag <= bus.to_rf_rs2_flag;
         bus.from_rf_rs1      <= bus.to_rf_rs1_flag ? regs[bus.to_rf_rs1] : 32'h0;
         bus.from_rf_rs2      <= bus.to_rf_rs2_flag ? regs[bus.to_rf_rs2] : 32'h0;
         bus.from_rf_index    <= bus.to_rf_index;
      end
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_op(input string tag, input logic v, input logic [31:0] idx,
                           input logic [31:0] rs1, input logic [31:0] rs2);
      check({tag, "_valid"}, 32'(bus.op_valid), 32'(v));
      if (v) begin
         check({tag, "_index"}, 32'(bus.op_index), idx);
         check({tag, "_rs1"}, bus.op_rs1, rs1);
         check({tag, "_rs2"}, bus.op_rs2, rs2);
      end
   endtask

   task automatic set_req(input logic v, input logic [1:0] idx, input logic f1, input logic f2,
                          input logic [4:0] r1, input logic [4:0] r2);
      bus.req_valid    = v;
      bus.req_index    = idx;
      bus.req_rs1_flag = f1;
      bus.req_rs2_flag = f2;
      bus.req_rs1      = r1;
      bus.req_rs2      = r2;
   endtask

   task automatic set_rob(input logic w, input logic [4:0] rd, input logic [31:0] d);
      bus.from_rob       = w;
      bus.from_rob_rd    = rd;
      bus.from_rob_wdata = d;
   endtask

   task automatic set_bb(input int k);
      set_req(1'b1, BB_IDX[k], BB_F1[k], BB_F2[k], BB_RS1[k], BB_RS2[k]);
   endtask

   initial begin
      rst_n_in = 1'b0;
      rdy_in   = 1'b1;
      flush_in = 1'b0;
      set_req(1'b1, 2'd1, 1'b1, 1'b1, 5'd5, 5'd6);
      set_rob(1'b0, 5'd0, 32'h0);
      tick();
      tick();
      check("rst_ready", 32'(bus.req_ready), 32'd0);
      check("rst_op_valid", 32'(bus.op_valid), 32'd0);
      check("rst_op_rs1", bus.op_rs1, 32'h0);
      check("rst_to_rf_flag", 32'(bus.to_rf_rs1_flag), 32'd0);
      rdy_in = 1'b0;
      tick();
      check("rst_nordy_op_valid", 32'(bus.op_valid), 32'd0);
      rdy_in = 1'b1;
      set_req(1'b0, 2'd0, 1'b0, 1'b0, 5'd0, 5'd0);
      rst_n_in = 1'b1;
      tick();
      check("post_rst_ready", 32'(bus.req_ready), 32'd1);

      // Single request, three-edge latency
      set_req(1'b1, 2'd1, 1'b1, 1'b1, 5'd5, 5'd6);
      tick();
      set_req(1'b0, 2'd0, 1'b0, 1'b0, 5'd0, 5'd0);
      check("single_no_issue_yet", 32'(bus.to_rf_rs1_flag), 32'd0);
      tick();
      check("single_to_rf_flag", 32'(bus.to_rf_rs1_flag), 32'd1);
      check("single_to_rf_rs1", 32'(bus.to_rf_rs1), 32'd5);
      check("single_to_rf_rs2", 32'(bus.to_rf_rs2), 32'd6);
      check("single_to_rf_index", 32'(bus.to_rf_index), 32'd1);
      tick();
      check_op("single_e2", 1'b0, 0, 0, 0);
      tick();
      check_op("single_e3", 1'b1, 1, 32'h11, 32'h22);
      tick();
      check_op("single_pulse", 1'b0, 0, 0, 0);

      // Commit on the RF read edge must bypass the stale read
      set_req(1'b1, 2'd2, 1'b1, 1'b0, 5'd7, 5'd3);
      tick();
      set_req(1'b0, 2'd0, 1'b0, 1'b0, 5'd0, 5'd0);
      tick();
      set_rob(1'b1, 5'd7, 32'hABCD);
      tick();
      set_rob(1'b0, 5'd0, 32'h0);
      tick();
      check_op("pend_bypass", 1'b1, 2, 32'hABCD, 32'h0);
      tick();

      // x0 is never bypassed
      set_req(1'b1, 2'd3, 1'b1, 1'b1, 5'd5, 5'd0);
      tick();
      set_req(1'b0, 2'd0, 1'b0, 1'b0, 5'd0, 5'd0);
      tick();
      set_rob(1'b1, 5'd0, 32'hFFFF);
      tick();
      set_rob(1'b1, 5'd0, 32'hFFFF);
      tick();
      set_rob(1'b0, 5'd0, 32'h0);
      check_op("x0_no_bypass", 1'b1, 3, 32'h11, 32'h0);
      tick();

      // Capture-edge commit, and newer write beating the pending one
      set_req(1'b1, 2'd0, 1'b1, 1'b1, 5'd8, 5'd9);
      tick();
      set_req(1'b0, 2'd0, 1'b0, 1'b0, 5'd0, 5'd0);
      tick();
      set_rob(1'b1, 5'd8, 32'h1111);
      tick();
      set_rob(1'b1, 5'd9, 32'h5A5A);
      tick();
      set_rob(1'b0, 5'd0, 32'h0);
      check_op("cap_bypass", 1'b1, 0, 32'h1111, 32'h5A5A);
      tick();
      set_req(1'b1, 2'd1, 1'b1, 1'b0, 5'd8, 5'd0);
      tick();
      set_req(1'b0, 2'd0, 1'b0, 1'b0, 5'd0, 5'd0);
      tick();
      set_rob(1'b1, 5'd8, 32'h3333);
      tick();
      set_rob(1'b1, 5'd8, 32'h4444);
      tick();
      set_rob(1'b0, 5'd0, 32'h0);
      check_op("newer_wins", 1'b1, 1, 32'h4444, 32'h0);
      tick();

      // Five back-to-back requests, one result per cycle in order
      set_bb(0);
      for (int t = 0; t <= 8; t++) begin
         tick();
         check($sformatf("bb_ready_t%0d", t), 32'(bus.req_ready), 32'd1);
         if (t >= 3 && t <= 7)
            check_op($sformatf("bb_k%0d", t - 3), 1'b1, 32'(BB_IDX[t-3]), BB_E1[t-3], BB_E2[t-3]);
         else if (t == 8)
            check_op("bb_done", 1'b0, 0, 0, 0);
         if (t + 1 < 5) set_bb(t + 1);
         else           set_req(1'b0, 2'd0, 1'b0, 1'b0, 5'd0, 5'd0);
      end

      // Same stream with rdy_in low for two edges
      next_k = 0;
      for (int t = 0; t <= 10; t++) begin
         rdy_in = (t != 4 && t != 5);
         if (next_k < 5) set_bb(next_k);
         else            set_req(1'b0, 2'd0, 1'b0, 1'b0, 5'd0, 5'd0);
         tick();
         if (rdy_in && bus.req_valid) next_k++;
         if (t < 3)       check_op($sformatf("stall_t%0d", t), 1'b0, 0, 0, 0);
         else if (t <= 5) check_op($sformatf("stall_hold_t%0d", t), 1'b1, 32'(BB_IDX[0]), BB_E1[0], BB_E2[0]);
         else if (t <= 9) check_op($sformatf("stall_k%0d", t - 5), 1'b1, 32'(BB_IDX[t-5]), BB_E1[t-5], BB_E2[t-5]);
         else             check_op("stall_done", 1'b0, 0, 0, 0);
      end
      rdy_in = 1'b1;
      set_req(1'b0, 2'd0, 1'b0, 1'b0, 5'd0, 5'd0);
      tick();

      // Flush with work queued, issued and pending; same-edge request dropped
      for (int k = 0; k < 3; k++) begin
         set_bb(k);
         tick();
      end
      set_bb(3);
      flush_in = 1'b1;
      tick();
      flush_in = 1'b0;
      set_req(1'b0, 2'd0, 1'b0, 1'b0, 5'd0, 5'd0);
      check_op("flush_op", 1'b0, 0, 0, 0);
      check("flush_rf_flag1", 32'(bus.to_rf_rs1_flag), 32'd0);
      check("flush_rf_flag2", 32'(bus.to_rf_rs2_flag), 32'd0);
      check("flush_ready", 32'(bus.req_ready), 32'd1);
      for (int t = 0; t < 4; t++) begin
         tick();
         check_op($sformatf("flush_after_t%0d", t), 1'b0, 0, 0, 0);
         check($sformatf("flush_rf_t%0d", t), 32'(bus.to_rf_rs1_flag), 32'd0);
      end
      set_req(1'b1, 2'd2, 1'b1, 1'b1, 5'd5, 5'd6);
      tick();
      set_req(1'b0, 2'd0, 1'b0, 1'b0, 5'd0, 5'd0);
      tick();
      tick();
      tick();
      check_op("post_flush", 1'b1, 2, 32'h11, 32'h22);

      // Reset mid-stream, with rdy_in low, discards in-flight work
      set_bb(0);
      tick();
      set_bb(1);
      tick();
      set_req(1'b0, 2'd0, 1'b0, 1'b0, 5'd0, 5'd0);
      rst_n_in = 1'b0;
      rdy_in   = 1'b0;
      tick();
      check_op("midrst_op", 1'b0, 0, 0, 0);
      check("midrst_rf_flag", 32'(bus.to_rf_rs1_flag), 32'd0);
      check("midrst_ready", 32'(bus.req_ready), 32'd0);
      rst_n_in = 1'b1;
      rdy_in   = 1'b1;
      for (int t = 0; t < 5; t++) begin
         tick();
         check_op($sformatf("midrst_after_t%0d", t), 1'b0, 0, 0, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
